// File: rtl/priority_dispatch_pkg.sv
// Shared types and helpers for the priority dispatcher: slot record and index-width function.

package priority_dispatch_pkg;

    localparam int unsigned SlotDataWidth = 32;

    typedef struct packed {
        logic                     valid;
        logic [SlotDataWidth-1:0] data;
    } slot_t;

    // Index width for n entries; never narrower than one bit so a 1-entry index stays legal.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/priority_dispatcher_if.sv
// Bundle of the producer stream, per-channel consumer handshakes and dispatch status.

interface priority_dispatcher_if #(
    parameter int unsigned OUTPUTS = 19,
    parameter int unsigned WIDTH   = 32
) ();
    import priority_dispatch_pkg::*;

    localparam int unsigned IDXW = idx_width(OUTPUTS);

    logic [OUTPUTS-1:0]            en_mask;
    logic                          i_valid;
    logic                          i_ready;
    logic [WIDTH-1:0]              i_data;
    logic [OUTPUTS-1:0]            o_valid;
    logic [OUTPUTS-1:0]            o_ready;
    logic [OUTPUTS-1:0][WIDTH-1:0] o_data;
    logic                          o_dispatch;
    logic [IDXW-1:0]               o_dest_idx;

    // Environment side: producer, consumers and enable control.
    modport master (
        output en_mask, i_valid, i_data, o_ready,
        input  i_ready, o_valid, o_data, o_dispatch, o_dest_idx
    );

    // Dispatcher side.
    modport slave (
        input  en_mask, i_valid, i_data, o_ready,
        output i_ready, o_valid, o_data, o_dispatch, o_dest_idx
    );

endinterface

// File: rtl/priority_first_one.sv
// Lowest-index-wins finder: binary tree over the request vector, zero-padded to a power of two.

module priority_first_one
    import priority_dispatch_pkg::*;
#(
    parameter  int unsigned N  = 2,
    localparam int unsigned IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    output logic          any,
    output logic [IW-1:0] idx
);

    localparam int unsigned P = 1 << IW;

    // Heap-ordered tree: node k has children 2k+1 / 2k+2, leaves start at P-1.
    always_comb begin
        logic [P-1:0]    req_pad;
        logic [2*P-2:0]  node_any;
        logic [IW-1:0]   node_idx [2*P-1];

        req_pad          = '0;
        req_pad[N-1:0]   = req;
        node_any         = '0;
        for (int k = 0; k < 2 * P - 1; k++) begin
            node_idx[k] = '0;
        end

        for (int i = 0; i < P; i++) begin
            node_any[P-1+i] = req_pad[i];
            node_idx[P-1+i] = IW'(i);
        end

        for (int k = P - 2; k >= 0; k--) begin
            node_any[k] = node_any[2*k+1] | node_any[2*k+2];
            node_idx[k] = node_any[2*k+1] ? node_idx[2*k+1] : node_idx[2*k+2];
        end

        any = node_any[0];
        idx = node_idx[0];
    end

endmodule

// File: rtl/priority_dispatcher.sv
// Fans one valid/ready stream out to OUTPUTS single-entry channel slots, lowest free index first.

module priority_dispatcher
    import priority_dispatch_pkg::*;
#(
    parameter int unsigned OUTPUTS = 19,
    parameter int unsigned WIDTH   = SlotDataWidth
) (
    input  logic                 clk,
    input  logic                 rst_n,
    priority_dispatcher_if.slave bus
);

    localparam int unsigned IDXW = idx_width(OUTPUTS);

    slot_t [OUTPUTS-1:0] slot_q;
    slot_t [OUTPUTS-1:0] slot_d;
    logic                dispatch_q;
    logic [IDXW-1:0]     dest_idx_q;

    logic [OUTPUTS-1:0]  valid_vec;
    logic [OUTPUTS-1:0]  free;
    logic                any_free;
    logic [IDXW-1:0]     dest;
    logic                accept;

    always_comb begin
        valid_vec = '0;
        for (int i = 0; i < OUTPUTS; i++) begin
            valid_vec[i] = slot_q[i].valid;
        end
    end

    // A slot draining this cycle is already free for the incoming word.
    assign free = (~valid_vec | bus.o_ready) & bus.en_mask;

    priority_first_one #(
        .N (OUTPUTS)
    ) u_first_one (
        .req (free),
        .any (any_free),
        .idx (dest)
    );

    assign bus.i_ready = any_free & rst_n;
    assign accept      = bus.i_valid & bus.i_ready;

    always_comb begin
        slot_d = slot_q;
        for (int i = 0; i < OUTPUTS; i++) begin
            if (slot_q[i].valid && bus.o_ready[i]) begin
                slot_d[i].valid = 1'b0;
            end
            // Refill after drain so a same-cycle write wins.
            if (accept && (dest == IDXW'(i))) begin
                slot_d[i].valid = 1'b1;
                slot_d[i].data  = SlotDataWidth'(bus.i_data);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_q     <= '0;
            dispatch_q <= 1'b0;
            dest_idx_q <= '0;
        end else begin
            slot_q     <= slot_d;
            dispatch_q <= accept;
            if (accept) begin
                dest_idx_q <= dest;
            end
        end
    end

    always_comb begin
        bus.o_data = '0;
        for (int i = 0; i < OUTPUTS; i++) begin
            bus.o_data[i] = slot_q[i].data[WIDTH-1:0];
        end
    end

    assign bus.o_valid    = valid_vec;
    assign bus.o_dispatch = dispatch_q;
    assign bus.o_dest_idx = dest_idx_q;

endmodule

// File: tb/tb_priority_dispatcher.sv
// Scoreboard bench for priority_dispatcher: reference slot model plus directed and random traffic.

module tb_priority_dispatcher;

    localparam int unsigned OUTPUTS = 19;
    localparam int unsigned WIDTH   = 32;
    localparam int unsigned IDXW    = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    priority_dispatcher_if #(.OUTPUTS(OUTPUTS), .WIDTH(WIDTH)) bus ();

    priority_dispatcher #(
        .OUTPUTS (OUTPUTS),
        .WIDTH   (WIDTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int               idx;
        logic [WIDTH-1:0] data;
    } exp_t;

    exp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model of slot state and dispatch registers.
    logic [OUTPUTS-1:0]            mv    = '0;
    logic [OUTPUTS-1:0][WIDTH-1:0] md    = '0;
    logic                          mdisp = 1'b0;
    logic [IDXW-1:0]               midx  = '0;

    // One clock: check i_ready mid-cycle, predict, then check registered outputs after the edge.
    task automatic cycle();
        logic [OUTPUTS-1:0] fr;
        int                 dest;
        logic               exp_ready;
        logic               acc;
        exp_t               e;

        #3;
        fr   = (~mv | bus.o_ready) & bus.en_mask;
        dest = -1;
        for (int i = OUTPUTS - 1; i >= 0; i--) begin
            if (fr[i]) dest = i;
        end
        exp_ready = rst_n && (dest >= 0);
        n_tests++;
        if (bus.i_ready !== exp_ready) begin
            n_fail++;
            $display("FAIL i_ready: got %b want %b at %0t", bus.i_ready, exp_ready, $time);
        end
        acc = bus.i_valid && exp_ready;
        if (acc) begin
            e.idx  = dest;
            e.data = bus.i_data;
            sb.push_back(e);
        end

        if (!rst_n) begin
            mv    = '0;
            md    = '0;
            mdisp = 1'b0;
            midx  = '0;
        end else begin
            mv = mv & ~bus.o_ready;
            if (acc) begin
                mv[dest] = 1'b1;
                md[dest] = bus.i_data;
                midx     = IDXW'(dest);
            end
            mdisp = acc;
        end

        @(posedge clk);
        #1;
        n_tests++;
        if (bus.o_dispatch !== mdisp) begin
            n_fail++;
            $display("FAIL o_dispatch: got %b want %b at %0t", bus.o_dispatch, mdisp, $time);
        end
        if (bus.o_dispatch === 1'b1) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_spurious: got dispatch want none at %0t", $time);
            end else begin
                e = sb.pop_front();
                n_tests++;
                if (bus.o_dest_idx !== IDXW'(e.idx)) begin
                    n_fail++;
                    $display("FAIL sb_dest: got %0d want %0d", bus.o_dest_idx, e.idx);
                end
                n_tests++;
                if (bus.o_valid[e.idx] !== 1'b1 || bus.o_data[e.idx] !== e.data) begin
                    n_fail++;
                    $display("FAIL sb_data: got %b/%h want 1/%h on ch %0d",
                             bus.o_valid[e.idx], bus.o_data[e.idx], e.data, e.idx);
                end
            end
        end
        n_tests++;
        if (bus.o_valid !== mv) begin
            n_fail++;
            $display("FAIL o_valid: got %h want %h at %0t", bus.o_valid, mv, $time);
        end
        n_tests++;
        if (bus.o_data !== md) begin
            n_fail++;
            $display("FAIL o_data: got %h want %h at %0t", bus.o_data, md, $time);
        end
        n_tests++;
        if (bus.o_dest_idx !== midx) begin
            n_fail++;
            $display("FAIL o_dest_idx: got %0d want %0d at %0t", bus.o_dest_idx, midx, $time);
        end
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        bus.en_mask = '1;
        bus.o_ready = '0;
        bus.i_valid = 1'b1;
        bus.i_data  = 32'h5A;
        cycle();
        cycle();
        n_tests++;
        if (bus.o_valid !== '0 || bus.o_dispatch !== 1'b0 || bus.o_dest_idx !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got %h/%b/%0d want 0/0/0",
                     bus.o_valid, bus.o_dispatch, bus.o_dest_idx);
        end
    endtask

    task automatic test_first_word();
        rst_n       = 1'b1;
        bus.o_ready = '1;
        bus.i_valid = 1'b1;
        bus.i_data  = 32'hA5;
        cycle();
        n_tests++;
        if (bus.o_valid !== OUTPUTS'(1) || bus.o_data[0] !== 32'hA5 ||
            bus.o_dispatch !== 1'b1 || bus.o_dest_idx !== '0) begin
            n_fail++;
            $display("FAIL first_word: got %h/%h/%b/%0d want 00001/a5/1/0",
                     bus.o_valid, bus.o_data[0], bus.o_dispatch, bus.o_dest_idx);
        end
        bus.i_valid = 1'b0;
        cycle();
    endtask

    task automatic test_back_to_back();
        bus.o_ready = '0;
        bus.i_valid = 1'b1;
        for (int w = 1; w <= 3; w++) begin
            bus.i_data = WIDTH'(w);
            cycle();
            n_tests++;
            if (bus.o_dest_idx !== IDXW'(w - 1)) begin
                n_fail++;
                $display("FAIL b2b_idx: got %0d want %0d", bus.o_dest_idx, w - 1);
            end
        end
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (bus.o_data[k] !== WIDTH'(k + 1)) begin
                n_fail++;
                $display("FAIL b2b_data: got %h want %h on ch %0d", bus.o_data[k], k + 1, k);
            end
        end
    endtask

    task automatic test_full_refill();
        bus.i_valid = 1'b1;
        for (int w = 4; w <= 19; w++) begin
            bus.i_data = WIDTH'(w);
            cycle();
        end
        bus.i_data = 32'hDEAD;
        #1;
        n_tests++;
        if (bus.i_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_stall: got i_ready %b want 0", bus.i_ready);
        end
        cycle();
        bus.o_ready[7] = 1'b1;
        bus.i_data     = 32'h77;
        #1;
        n_tests++;
        if (bus.i_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL refill_ready: got i_ready %b want 1", bus.i_ready);
        end
        cycle();
        n_tests++;
        if (bus.o_valid[7] !== 1'b1 || bus.o_data[7] !== 32'h77 || bus.o_dest_idx !== IDXW'(7)) begin
            n_fail++;
            $display("FAIL refill: got %b/%h/%0d want 1/77/7",
                     bus.o_valid[7], bus.o_data[7], bus.o_dest_idx);
        end
        bus.o_ready = '0;
        bus.i_valid = 1'b0;
        cycle();
    endtask

    task automatic test_en_mask();
        bus.o_ready = '1;
        cycle();
        bus.en_mask = OUTPUTS'(4);
        bus.i_valid = 1'b1;
        bus.i_data  = 32'hBEEF;
        cycle();
        n_tests++;
        if (bus.o_valid !== OUTPUTS'(4) || bus.o_data[2] !== 32'hBEEF) begin
            n_fail++;
            $display("FAIL en_single: got %h/%h want 00004/beef", bus.o_valid, bus.o_data[2]);
        end
        bus.en_mask = '0;
        #1;
        n_tests++;
        if (bus.i_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL en_zero: got i_ready %b want 0", bus.i_ready);
        end
        cycle();
        n_tests++;
        if (bus.o_dispatch !== 1'b0) begin
            n_fail++;
            $display("FAIL en_zero_disp: got %b want 0", bus.o_dispatch);
        end
        bus.i_valid = 1'b0;
        bus.en_mask = '1;
    endtask

    task automatic test_hold_drain();
        bus.o_ready = '0;
        bus.en_mask = OUTPUTS'(8);
        bus.i_valid = 1'b1;
        bus.i_data  = 32'h33;
        cycle();
        bus.i_valid = 1'b0;
        bus.en_mask = '0;
        for (int c = 0; c < 3; c++) begin
            cycle();
            n_tests++;
            if (bus.o_valid[3] !== 1'b1 || bus.o_data[3] !== 32'h33) begin
                n_fail++;
                $display("FAIL hold: got %b/%h want 1/33", bus.o_valid[3], bus.o_data[3]);
            end
        end
        bus.o_ready[3] = 1'b1;
        cycle();
        n_tests++;
        if (bus.o_valid[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_masked: got %b want 0", bus.o_valid[3]);
        end
        bus.o_ready = '0;
        bus.en_mask = '1;
    endtask

    task automatic test_reset_mid();
        bus.i_valid = 1'b1;
        for (int w = 0; w < 4; w++) begin
            bus.i_data = 32'h40 + WIDTH'(w);
            cycle();
        end
        rst_n      = 1'b0;
        bus.i_data = 32'h99;
        cycle();
        n_tests++;
        if (bus.o_valid !== '0 || bus.o_dispatch !== 1'b0 || bus.o_dest_idx !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: got %h/%b/%0d want 0/0/0",
                     bus.o_valid, bus.o_dispatch, bus.o_dest_idx);
        end
        rst_n       = 1'b1;
        bus.i_valid = 1'b0;
        cycle();
        n_tests++;
        if (bus.o_dispatch !== 1'b0 || bus.o_valid !== '0) begin
            n_fail++;
            $display("FAIL reset_word_dropped: got %b/%h want 0/0", bus.o_dispatch, bus.o_valid);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            bus.en_mask = ($urandom_range(0, 1) == 0) ? '1 : OUTPUTS'($urandom);
            bus.o_ready = OUTPUTS'($urandom & $urandom);
            bus.i_valid = ($urandom_range(0, 3) != 0);
            bus.i_data  = $urandom;
            cycle();
        end
        bus.i_valid = 1'b0;
        bus.o_ready = '1;
        cycle();
        cycle();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: got %0d entries want 0", sb.size());
        end
    endtask

    initial begin
        bus.en_mask = '1;
        bus.o_ready = '0;
        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        test_reset();
        test_first_word();
        test_back_to_back();
        test_full_refill();
        test_en_mask();
        test_hold_drain();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
